// File: rtl/jtframe_rstcen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_rstcen_pkg
// Description : Shared state encoding and sizing helper for the PLL reset/cen
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jtframe_rstcen_pkg;

    typedef logic [1:0] rstcen_state_t;

    localparam rstcen_state_t ST_WAIT_LOCK = 2'd0;
    localparam rstcen_state_t ST_STABLE    = 2'd1;
    localparam rstcen_state_t ST_HOLD      = 2'd2;
    localparam rstcen_state_t ST_RUN       = 2'd3;

    // Width able to hold the larger of the two terminal counts minus one.
    function automatic int cnt_width(input int lock_cycles, input int hold_cycles);
        int m;
        m = (lock_cycles > hold_cycles) ? lock_cycles : hold_cycles;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_frac_cen_acc.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_frac_cen_acc
// Description : Fractional clock enable (average rate num/den) with a
//               half-rate companion pulse on every second enable.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_frac_cen_acc #(
    parameter int CENW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CENW-1:0] num,
    input  logic [CENW-1:0] den,
    output logic            cen,
    output logic            cen2
);

    logic [CENW:0] r_acc;
    logic          r_tog;
    logic [CENW:0] w_sum;
    logic [CENW:0] w_diff;

    // acc stays below 2**CENW, so sum fits in CENW+1 bits
    always_comb begin
        w_sum  = r_acc + {1'b0, num};
        w_diff = w_sum - {1'b0, den};
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_acc <= '0;
            r_tog <= 1'b0;
            cen   <= 1'b0;
            cen2  <= 1'b0;
        end else if (den == '0) begin
            cen   <= 1'b0;
            cen2  <= 1'b0;
        end else if (num >= den) begin
            r_acc <= '0;
            cen   <= 1'b1;
            cen2  <= r_tog;
            r_tog <= ~r_tog;
        end else if (w_sum >= {1'b0, den}) begin
            r_acc <= w_diff;
            cen   <= 1'b1;
            cen2  <= r_tog;
            r_tog <= ~r_tog;
        end else begin
            r_acc <= w_sum;
            cen   <= 1'b0;
            cen2  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_pll_rstcen.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_pll_rstcen
// Description : Debounces the PLL lock flag, sequences the system reset and
//               drives the fractional clock enables for core logic.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_pll_rstcen
    import jtframe_rstcen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 256,
    parameter int CENW        = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pll_locked,
    input  logic [CENW-1:0] num,
    input  logic [CENW-1:0] den,
    output logic            rst_sys,
    output logic            rst_sys_n,
    output logic            cen,
    output logic            cen2,
    output logic            lock_ok
);

    localparam int          CW          = cnt_width(LOCK_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] C_LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    rstcen_state_t          r_state;
    logic [CW-1:0]          r_cnt;
    logic                   w_lk_s;
    logic                   w_active;

    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end

    assign w_lk_s   = r_sync[SYNC_STAGES-1];
    assign w_active = (r_state == ST_HOLD) || (r_state == ST_RUN);

    // Any low lk_s sends the sequence back to the start of the lock count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_cnt <= '0;
                    if (w_lk_s) r_state <= ST_STABLE;
                end
                ST_STABLE: begin
                    if (!w_lk_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LOCK_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!w_lk_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_HOLD_LAST) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cnt <= '0;
                    if (!w_lk_s) r_state <= ST_WAIT_LOCK;
                end
                default: begin
                    r_state <= ST_WAIT_LOCK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs follow the state register by one cycle, aligned with cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_sys   <= 1'b1;
            rst_sys_n <= 1'b0;
            lock_ok   <= 1'b0;
        end else begin
            rst_sys   <= (r_state != ST_RUN);
            rst_sys_n <= (r_state == ST_RUN);
            lock_ok   <= w_active;
        end
    end

    jtframe_frac_cen_acc #(
        .CENW (CENW)
    ) u_cen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_active),
        .num  (num),
        .den  (den),
        .cen  (cen),
        .cen2 (cen2)
    );

endmodule
`default_nettype wire

// File: tb/tb_jtframe_pll_rstcen.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtframe_pll_rstcen
// Description : Self-checking bench: lock-history model plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_pll_rstcen;

    localparam int S    = 2;
    localparam int L    = 16;
    localparam int H    = 8;
    localparam int CENW = 10;
    localparam int MAXC = 16384;

    logic            clk = 1'b0;
    logic            rst;
    logic            pll_locked;
    logic [CENW-1:0] num;
    logic [CENW-1:0] den;
    logic            rst_sys, rst_sys_n, cen, cen2, lock_ok;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    jtframe_pll_rstcen #(
        .SYNC_STAGES (S),
        .LOCK_CYCLES (L),
        .HOLD_CYCLES (H),
        .CENW        (CENW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .num        (num),
        .den        (den),
        .rst_sys    (rst_sys),
        .rst_sys_n  (rst_sys_n),
        .cen        (cen),
        .cen2       (cen2),
        .lock_ok    (lock_ok)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The state after an edge is decided by how many consecutive valid lock
    // samples (taken after the last rst) end S edges earlier.
    bit vs [0:MAXC-1];
    int last_rst = 0;
    int m_acc    = 0;
    bit m_tog    = 1'b0;
    logic e_rst_sys, e_rst_sys_n, e_cen, e_cen2, e_lock_ok;

    always @(posedge clk) begin
        int k, idx, s;
        bit hr, rn;
        cyc = cyc + 1;
        if (cyc < MAXC) vs[cyc] = pll_locked && !rst;
        if (rst) begin
            last_rst    = cyc;
            m_acc       = 0;
            m_tog       = 1'b0;
            e_rst_sys   = 1'b1;
            e_rst_sys_n = 1'b0;
            e_cen       = 1'b0;
            e_cen2      = 1'b0;
            e_lock_ok   = 1'b0;
        end else begin
            k   = 0;
            idx = cyc - 1 - S;
            while (idx >= 1 && idx > last_rst && idx < MAXC && vs[idx] && k < L + H + 1) begin
                k++;
                idx--;
            end
            hr = (k >= L + 1);
            rn = (k >= L + H + 1);
            e_lock_ok   = hr;
            e_rst_sys   = !rn;
            e_rst_sys_n = rn;
            e_cen2      = 1'b0;
            if (!hr) begin
                m_acc = 0;
                m_tog = 1'b0;
                e_cen = 1'b0;
            end else if (den == 0) begin
                e_cen = 1'b0;
            end else if (num >= den) begin
                m_acc  = 0;
                e_cen  = 1'b1;
                e_cen2 = m_tog;
                m_tog  = !m_tog;
            end else begin
                s = m_acc + int'(num);
                if (s >= int'(den)) begin
                    m_acc  = s - int'(den);
                    e_cen  = 1'b1;
                    e_cen2 = m_tog;
                    m_tog  = !m_tog;
                end else begin
                    m_acc = s;
                    e_cen = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk_bit("model_rst_sys",   rst_sys,   e_rst_sys);
            chk_bit("model_rst_sys_n", rst_sys_n, e_rst_sys_n);
            chk_bit("model_cen",       cen,       e_cen);
            chk_bit("model_cen2",      cen2,      e_cen2);
            chk_bit("model_lock_ok",   lock_ok,   e_lock_ok);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // which=0: lock_ok rises, which=1: rst_sys falls
    task automatic wait_out(input int which, input int exp_cyc, input string nm);
        int got;
        got = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((which == 0 && lock_ok === 1'b1) || (which == 1 && rst_sys === 1'b0)) begin
                got = cyc;
                break;
            end
        end
        chk_int(nm, got, exp_cyc);
    endtask

    task automatic count_cen(input int n, output int c1, output int c2);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cen === 1'b1)  c1++;
            if (cen2 === 1'b1) c2++;
        end
    endtask

    initial begin
        int c, r, c1, c2, last, gap, pgap, bad, first;
        rst        = 1'b1;
        pll_locked = 1'b0;
        num        = 10'd1;
        den        = 10'd8;
        repeat (3) tick();
        chk_bit("reset_rst_sys",   rst_sys,   1'b1);
        chk_bit("reset_rst_sys_n", rst_sys_n, 1'b0);
        chk_bit("reset_lock_ok",   lock_ok,   1'b0);
        repeat (2) tick();
        rst = 1'b0;
        while (cyc < 9) tick();
        pll_locked = 1'b1;
        wait_out(0, 29, "release_lock_ok");
        wait_out(1, 37, "release_rst_sys");

        // 1/8 in RUN
        c1 = 0; c2 = 0; last = -1; bad = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (cen === 1'b1) begin
                if (last >= 0 && cyc - last != 8) bad++;
                last = cyc;
                c1++;
            end
            if (cen2 === 1'b1) c2++;
        end
        chk_int("frac_1_8_cen",  c1, 100);
        chk_int("frac_1_8_cen2", c2, 50);
        chk_int("frac_1_8_spacing_errors", bad, 0);

        // 3/8: phase carried over
        num = 10'd3;
        c1 = 0; last = -1; pgap = -1; bad = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (cen === 1'b1) begin
                if (last >= 0) begin
                    gap = cyc - last;
                    if (pgap >= 0 && (gap - pgap > 1 || pgap - gap > 1)) bad++;
                    pgap = gap;
                end
                last = cyc;
                c1++;
            end
        end
        chk_int("frac_3_8_cen", c1, 300);
        chk_int("frac_3_8_gap_errors", bad, 0);

        den = 10'd0;
        count_cen(100, c1, c2);
        chk_int("den0_cen", c1, 0);

        num = 10'd8; den = 10'd8;
        count_cen(100, c1, c2);
        chk_int("num_eq_den_cen", c1, 100);

        num = 10'd9;
        count_cen(100, c1, c2);
        chk_int("num_gt_den_cen", c1, 100);

        // acc left at 0 => 1/8 first pulse on the 8th cycle
        num = 10'd1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cen === 1'b1) begin
                first = i;
                break;
            end
        end
        chk_int("num_gt_den_acc_zero", first, 8);

        num = 10'd0;
        count_cen(100, c1, c2);
        chk_int("num0_cen", c1, 0);

        // lock loss in RUN with cen active
        num = 10'd8; den = 10'd8;
        repeat (3) tick();
        pll_locked = 1'b0;
        repeat (4) tick();
        chk_bit("loss_rst_sys", rst_sys, 1'b1);
        chk_bit("loss_cen",     cen,     1'b0);
        chk_bit("loss_cen2",    cen2,    1'b0);
        chk_bit("loss_lock_ok", lock_ok, 1'b0);
        tick();
        pll_locked = 1'b1;
        c = cyc;
        wait_out(0, c + 20, "relock_lock_ok");
        wait_out(1, c + 28, "relock_rst_sys");

        // glitch in STABLE restarts the count
        pll_locked = 1'b0;
        repeat (6) tick();
        pll_locked = 1'b1;
        c = cyc;
        repeat (8) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_out(0, c + 10 + 19, "glitch_lock_ok");
        wait_out(1, c + 10 + 27, "glitch_rst_sys");

        // rst pulse while in HOLD with cen active
        pll_locked = 1'b0;
        repeat (6) tick();
        pll_locked = 1'b1;
        c = cyc;
        wait_out(0, c + 20, "hold_lock_ok");
        repeat (2) tick();
        chk_bit("hold_cen_active", cen, 1'b1);
        rst = 1'b1;
        tick();
        chk_bit("midhold_rst_sys",   rst_sys,   1'b1);
        chk_bit("midhold_rst_sys_n", rst_sys_n, 1'b0);
        chk_bit("midhold_cen",       cen,       1'b0);
        chk_bit("midhold_cen2",      cen2,      1'b0);
        chk_bit("midhold_lock_ok",   lock_ok,   1'b0);
        rst = 1'b0;
        r = cyc;
        wait_out(0, r + 20, "after_rst_lock_ok");
        wait_out(1, r + 28, "after_rst_rst_sys");

        repeat (3) tick();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
